// File: rtl/adc_scan_ctrl.sv
// Round-robin MCP3008-style scanner: drives 3-byte SPI frames and emits one 10-bit result per frame.
// Latency: CS_SETUP + 3*(1 + SPI byte time) + CS_HOLD cycles from chip-select fall to sample_valid_o.
// Backpressure: sample_ready_i low holds the result and stalls the next frame; nothing is dropped.
module adc_scan_ctrl #(
    parameter int NUM_CH   = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 16
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic [9:0]        sample_data_o,
    output logic [2:0]        sample_ch_o,
    output logic              busy_o,
    output logic              spi_start_o,
    output logic [7:0]        spi_tx_o,
    input  logic              spi_done_i,
    input  logic [7:0]        spi_rx_i,
    output logic              CS_n_o
);

    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ?
                             ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                             ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_HOLD,
        S_OUTPUT,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic          cs_n_q, cs_n_d;
    logic [2:0]    cur_ch_q, cur_ch_d;
    logic [2:0]    last_ch_q, last_ch_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [1:0]    rx1_lo_q, rx1_lo_d;
    logic [7:0]    rx2_q, rx2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic [9:0]    data_q, data_d;
    logic [2:0]    ch_q, ch_d;

    logic [7:0]    mask8;
    logic [2:0]    pick_ch;
    logic [2:0]    cand;
    logic          can_launch;
    logic          launch;

    assign mask8      = 8'(ch_mask_i);
    assign can_launch = enable_i && (ch_mask_i != '0);

    // Walk downward so the lowest offset past last_ch wins; wrap is modulo NUM_CH.
    always_comb begin
        pick_ch = '0;
        cand    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = 3'((int'(last_ch_q) + i) % NUM_CH);
            if (mask8[cand]) pick_ch = cand;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        cur_ch_d   = cur_ch_q;
        last_ch_d  = last_ch_q;
        byte_idx_d = byte_idx_q;
        rx1_lo_d   = rx1_lo_q;
        rx2_d      = rx2_q;
        cnt_d      = cnt_q;
        vld_d      = vld_q;
        data_d     = data_q;
        ch_d       = ch_q;
        launch     = 1'b0;

        case (state_q)
            S_IDLE: launch = can_launch;
            S_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (spi_done_i) begin
                    if (byte_idx_q == 2'd1) rx1_lo_d = spi_rx_i[1:0];
                    if (byte_idx_q == 2'd2) rx2_d = spi_rx_i;
                    if (byte_idx_q < 2'd2) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = S_START;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    cs_n_d    = 1'b1;
                    data_d    = {rx1_lo_q, rx2_q};
                    ch_d      = cur_ch_q;
                    vld_d     = 1'b1;
                    last_ch_d = cur_ch_q;
                    cnt_d     = '0;
                    state_d   = S_OUTPUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The gap counter runs from chip-select rise and saturates, so it overlaps the handshake.
            S_OUTPUT: begin
                if (cnt_q != CW'(CS_GAP)) cnt_d = cnt_q + 1'b1;
                if (sample_ready_i) begin
                    vld_d   = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q != CW'(CS_GAP)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (can_launch) begin
                    launch = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d    = S_SETUP;
            cur_ch_d   = pick_ch;
            cs_n_d     = 1'b0;
            byte_idx_d = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            cs_n_q     <= 1'b1;
            cur_ch_q   <= '0;
            last_ch_q  <= 3'(NUM_CH - 1);
            byte_idx_q <= '0;
            rx1_lo_q   <= '0;
            rx2_q      <= '0;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            ch_q       <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            cur_ch_q   <= cur_ch_d;
            last_ch_q  <= last_ch_d;
            byte_idx_q <= byte_idx_d;
            rx1_lo_q   <= rx1_lo_d;
            rx2_q      <= rx2_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
        end
    end

    always_comb begin
        case (byte_idx_q)
            2'd0:    spi_tx_o = 8'h01;
            2'd1:    spi_tx_o = {1'b1, cur_ch_q, 4'b0000};
            default: spi_tx_o = 8'h00;
        endcase
    end

    assign spi_start_o    = (state_q == S_START);
    assign busy_o         = (state_q != S_IDLE);
    assign CS_n_o         = cs_n_q;
    assign sample_valid_o = vld_q;
    assign sample_data_o  = data_q;
    assign sample_ch_o    = ch_q;

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Round-robin channel scanner that sequences the SPI master through 3-byte ADC conversion frames (MCP3008-style, single-ended) and emits one result per frame on a valid/ready stream. It sits between the SPI master's start/done control interface and the acquisition datapath. It owns frame-level chip select, byte sequencing, and channel selection; per-byte SCLK, shifting and inter-byte hold timing stay inside the SPI master.

## Interface
Parameters:
- NUM_CH, default 8: number of ADC channels, 1..8.
- CS_SETUP, default 4: clock cycles from CS_n_o falling to the first spi_start_o, minimum 1.
- CS_HOLD, default 4: clock cycles from the last spi_done_i to CS_n_o rising, minimum 1.
- CS_GAP, default 16: minimum clock cycles CS_n_o stays high between frames, minimum 1.

Ports:
- clock_i, input, 1: the single clock for the block.
- reset_ni, input, 1: reset, asynchronous and active-low.
- enable_i, input, 1: scan while high; sampled at frame boundaries.
- ch_mask_i, input, NUM_CH: bit k set means channel k is included in the scan.
- sample_valid_o, output, 1: a result is available.
- sample_ready_i, input, 1: the consumer accepts the result.
- sample_data_o, output, 10: conversion result.
- sample_ch_o, output, 3: channel number of the result.
- busy_o, output, 1: high in any state other than IDLE.
- spi_start_o, output, 1: one-cycle start pulse to the SPI master.
- spi_tx_o, output, 8: byte to transmit.
- spi_done_i, input, 1: one-cycle byte-complete pulse from the SPI master.
- spi_rx_i, input, 8: received byte; valid while spi_done_i is high.
- CS_n_o, output, 1: ADC chip select, active-low.

## Operation
- States: IDLE, SETUP, START, WAIT, HOLD, OUTPUT, GAP.
- Registers:
  - last_ch, 3 bits, reset value NUM_CH-1.
  - cur_ch, 3 bits.
  - byte_idx, 2 bits.
  - rx1_lo, 2 bits.
  - rx2, 8 bits.
  - cycle counter, wide enough for max(CS_SETUP, CS_HOLD, CS_GAP).
- Channel pick is combinational: the first set bit of ch_mask_i searching upward from last_ch+1, wrapping modulo NUM_CH. The mask is sampled only on the cycle the pick is made.
- IDLE to SETUP requires enable_i=1 and ch_mask_i nonzero. On that transition:
  - cur_ch is loaded with the pick.
  - CS_n_o is driven low.
  - byte_idx is set to 0.
  - The counter is cleared.
- If enable_i=1 but the mask is all-zero, the block stays in IDLE.
- SETUP: counts CS_SETUP cycles, then goes to START.
- START: spi_start_o=1 for exactly one cycle, then goes to WAIT.
- spi_tx_o is combinational from byte_idx:
  - byte_idx 0: 8'h01.
  - byte_idx 1: {1'b1, cur_ch, 4'b0000}.
  - byte_idx 2: 8'h00.
- spi_tx_o stays stable from START until spi_done_i is received.
- WAIT: on spi_done_i:
  - byte_idx 1: capture spi_rx_i[1:0] into rx1_lo.
  - byte_idx 2: capture spi_rx_i into rx2.
  - byte_idx 0: received data is discarded.
  - If byte_idx < 2: increment byte_idx and go to START.
  - Otherwise go to HOLD.
- HOLD: counts CS_HOLD cycles, then:
  - CS_n_o goes high.
  - sample_data_o is set to {rx1_lo, rx2}.
  - sample_ch_o is set to cur_ch.
  - sample_valid_o is set to 1.
  - last_ch is set to cur_ch.
  - Next state is OUTPUT.
- OUTPUT: sample_valid_o, sample_data_o and sample_ch_o are held stable until sample_valid_o && sample_ready_i. The transfer completes in that cycle and the block goes to GAP. Backpressure stalls scanning; no samples are dropped.
- GAP: counts CS_GAP cycles, counted from CS_n_o rising, so the gap overlaps OUTPUT. GAP is left only once the gap has elapsed and the handshake is complete:
  - If enable_i=1 and the mask is nonzero: pick the next channel and go to SETUP. This is the same action as IDLE to SETUP.
  - Otherwise: go to IDLE.
- A falling enable_i never aborts a frame. The current frame, including its output handshake and gap, always completes.
- spi_done_i outside WAIT is ignored.
- Reset:
  - Asserting reset_ni forces the state to IDLE and all outputs to their reset values immediately, mid-frame included. The in-flight sample is discarded.
  - Output reset values: CS_n_o=1, spi_start_o=0, spi_tx_o=8'h01, sample_valid_o=0, sample_data_o=0, sample_ch_o=0, busy_o=0.
  - After reset the scan restarts from channel 0.

## Timing
- The SPI master's done_i pulse lands at least 1 cycle after spi_start_o. The next spi_start_o is issued no earlier than 1 cycle after spi_done_i, so start never coincides with done.
- CS_n_o falls at cycle T (the SETUP entry edge). The first spi_start_o is high in cycle T+CS_SETUP.
- sample_valid_o rises on the same edge that CS_n_o rises, CS_HOLD cycles after the cycle of the third spi_done_i.
- Frame length = CS_SETUP + 3 × (1 + SPI byte time) + CS_HOLD cycles.
- Frame-to-frame period = frame length + max(CS_GAP, handshake wait) + 1 pick cycle.
- Width rules:
  - The channel search wraps modulo NUM_CH, not modulo 8.
  - Mask bits are NUM_CH wide, so no out-of-range channel can be picked.
  - sample_data_o width is fixed at 10 bits.
- Simultaneous events:
  - spi_done_i together with the last byte: HOLD counting starts on the next cycle.
  - sample_ready_i high on the first valid cycle: a 1-cycle handshake.
  - A mask change during a frame affects only the next pick.

## Test plan
- Single channel, mask=8'h08, constant ready=1, ADC model returns rx bytes 8'hxx, 8'hx2, 8'hAB:
  - Transmitted bytes are 01, B0, 00.
  - Output is data=10'h2AB, ch=3.
  - Frames repeat on ch 3.
- Round-robin, mask=8'b1010_0101: the channel sequence is 0, 2, 5, 7, 0, …, and each sample_ch_o matches the byte-1 channel field.
- Backpressure, ready=0 for 50 cycles after valid:
  - valid, data and ch are held stable.
  - CS_n_o stays high.
  - No new spi_start_o occurs until 1 cycle after acceptance plus any remaining gap.
- Timing check:
  - CS_n_o low to first start = CS_SETUP cycles.
  - Last done to CS_n_o high = CS_HOLD.
  - CS_n_o high ≥ CS_GAP cycles.
  - Exactly 3 start pulses per CS-low window.
- Disable and mask handling:
  - enable_i dropped mid-frame: the frame completes, its sample is emitted, then the block returns to IDLE with busy_o=0.
  - mask=0 with enable_i=1: the block stays in IDLE with CS_n_o=1.
- Reset mid-frame, reset_ni low while in WAIT of byte 1:
  - CS_n_o=1 and sample_valid_o=0 immediately.
  - After release, the first frame converts channel 0 (mask=8'hFF).
